alarm_input_conditioner: RTL
============================

Name: alarm_input_conditioner

Overview:
- Conditions the raw board inputs that feed the NIOS alarm-clock CPU: two edit push-buttons and three mode switches.
- Synchronises and debounces every input, and generates press and auto-repeat events for each button.
- Holds each button event as a sticky flag until the CPU acknowledges it, so polled PIO reads never miss a press.
- Sits between the board pins and the CPU's btn_edit/sw_states PIO inputs.

Parameters:
- N_BTN, 2, number of edit buttons.
- N_SW, 3, number of mode switches.
- BTN_ACTIVE_LOW, 1, 1 means a raw button reads 0 when pressed.
- DEBOUNCE_CYCLES, 1000000, cycles an input must stay stable before a change is accepted (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles of continuous hold after the accepted press before the first repeat event.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat events while the button stays held.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_BTN  unsynchronised button pins.
- sw_raw  in  N_SW  unsynchronised switch pins.
- btn_ack  in  N_BTN  one-cycle per-bit clear of btn_evt from the CPU side.
- btn_level  out  N_BTN  debounced pressed state, active-high.
- btn_evt  out  N_BTN  sticky event flag, goes to the CPU btn_edit input.
- sw_level  out  N_SW  debounced switch state, goes to the CPU sw_states input.

Behaviour:
- Reset (asynchronous, reset_reset_n=0): all synchronisers, counters and flags clear; FSMs go to IDLE.
  - btn_level=0, btn_evt=0.
  - sw_level=0.
  - Leaving reset, the first accepted switch value appears only after DEBOUNCE_CYCLES of stability.
- Synchronisation: each raw bit passes through a 2-FF synchroniser.
  - Buttons are polarity-normalised after the synchroniser: pressed=1.
- Debounce: a counter per bit restarts whenever the synchronised value differs from the accepted value.
  - The accepted value updates only when the counter reaches DEBOUNCE_CYCLES-1 with the difference still present.
  - Any glitch shorter than DEBOUNCE_CYCLES is fully rejected.
  - Latency from a clean raw edge to the accepted value is 2+DEBOUNCE_CYCLES cycles.
- Button FSM, one instance per button:
  - IDLE: on accepted press, raise an event, load the repeat counter with REPEAT_DELAY, go to HOLD_DELAY.
  - HOLD_DELAY: count down. On accepted release go to IDLE. On reaching 0, raise an event, reload with REPEAT_PERIOD, go to HOLD_REPEAT.
  - HOLD_REPEAT: on reaching 0, raise an event and reload. On accepted release go to IDLE.
  - A release always wins over a same-cycle counter expiry; no event is raised in that case.
- btn_evt (sticky):
  - Set on a raised event; cleared by btn_ack.
  - Set and ack in the same cycle: btn_evt stays 1, because the new event wins.
  - Events raised while btn_evt is already 1 merge into it; there is no counting and no overflow.
- btn_level and sw_level are the accepted values, registered with no extra delay.
- Counter widths are $clog2(max(parameter)+1); they saturate and never wrap.
- All outputs are registered; there are no combinational paths from any input to any output.

Decomposition:
- Package alarm_io_pkg:
  - button FSM state enum (IDLE, HOLD_DELAY, HOLD_REPEAT);
  - default timing constants;
  - a width helper function.
- Sub-module debounce_bit: 2-FF synchroniser plus debounce counter, one bit.
  - Instantiated N_BTN+N_SW times by generate loops.
- The button FSM and sticky flag stay inline in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, BTN_ACTIVE_LOW=1):
- Hold btn_raw[0]=0 -> btn_level[0]=1 and btn_evt[0]=1 six cycles after the edge; pulse btn_ack[0] -> btn_evt[0]=0 on the next cycle.
- Pulse btn_raw[1]=0 for 3 cycles, then 1 -> btn_level[1] and btn_evt[1] stay 0 throughout.
- Hold btn_raw[0] low, acking each event -> events at t=6, 26, 34, 42; release -> no further events after btn_level falls.
- Release timed to coincide with repeat expiry -> FSM goes to IDLE and no event is raised. Separately, btn_ack asserted in the same cycle as a new event -> btn_evt remains 1.
- Drive sw_raw 3'b000->3'b101, with 2-cycle bounces on bit 2 -> sw_level=3'b101 only after 4 stable cycles; intermediate values never appear.
- Assert reset_reset_n=0 mid-repeat, asynchronously between clock edges -> all outputs 0 immediately; after release with the button still held, a fresh press event appears after 2+DEBOUNCE_CYCLES cycles.

Source files
------------

// File: rtl/alarm_io_pkg.sv
// Shared types, default timing and sizing helpers for the alarm-clock input conditioner.
package alarm_io_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HOLD_DELAY  = 2'd1,
      HOLD_REPEAT = 2'd2
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;

   // Width of a counter that must hold the larger of two terminal counts.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, optional polarity flip, then a stability-counter debounce.
module debounce_bit
   import alarm_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic level,
   output logic level_nxt
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, 0);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic          sync_n;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;

   // Synchroniser resets to the inactive raw level so the normalised value starts released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= INVERT;
         sync_q  <= INVERT;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         meta_q  <= raw_in;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign sync_n = sync_q ^ INVERT;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_n != level_q) begin
         if (cnt_q >= CNT_LAST) begin
            level_d = sync_n;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level     = level_q;
   assign level_nxt = level_d;

endmodule

// File: rtl/alarm_input_conditioner.sv
// Debounces the alarm-clock buttons and switches, and turns button holds into sticky
// press / auto-repeat event flags that the CPU polls and acknowledges.
module alarm_input_conditioner
   import alarm_io_pkg::*;
#(
   parameter int N_BTN           = 2,
   parameter int N_SW            = 3,
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   input  logic [N_BTN-1:0] btn_ack,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_evt,
   output logic [N_SW-1:0]  sw_level
);

   localparam int RW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);
   localparam logic [RW-1:0] RPT_ONE    = RW'(1);

   logic [N_BTN-1:0] btn_lvl;
   logic [N_BTN-1:0] btn_nxt;
   logic [N_SW-1:0]  sw_lvl;
   logic [N_SW-1:0]  sw_nxt_unused;

   for (genvar si = 0; si < N_SW; si++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (1'b0)
      ) u_db (
         .clk       (clk_clk),
         .rst_n     (reset_reset_n),
         .raw_in    (sw_raw[si]),
         .level     (sw_lvl[si]),
         .level_nxt (sw_nxt_unused[si])
      );
   end

   for (genvar bi = 0; bi < N_BTN; bi++) begin : g_btn
      btn_state_e state_q;
      btn_state_e state_d;
      logic [RW-1:0] rpt_q;
      logic [RW-1:0] rpt_d;
      logic          evt_q;
      logic          evt_d;
      logic          rise;
      logic          fall;
      logic          raise;

      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (BTN_ACTIVE_LOW != 0)
      ) u_db (
         .clk       (clk_clk),
         .rst_n     (reset_reset_n),
         .raw_in    (btn_raw[bi]),
         .level     (btn_lvl[bi]),
         .level_nxt (btn_nxt[bi])
      );

      // Acting on the debouncer's next value lets the event land on the same edge as btn_level.
      assign rise = btn_nxt[bi] & ~btn_lvl[bi];
      assign fall = ~btn_nxt[bi] & btn_lvl[bi];

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            state_q <= IDLE;
            rpt_q   <= '0;
            evt_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            evt_q   <= evt_d;
         end
      end

      // Release is tested before expiry so a release on the expiry edge never raises an event.
      always_comb begin
         state_d = state_q;
         rpt_d   = rpt_q;
         raise   = 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  raise   = 1'b1;
                  rpt_d   = RPT_DELAY;
                  state_d = HOLD_DELAY;
               end
            end
            HOLD_DELAY, HOLD_REPEAT: begin
               if (fall) begin
                  rpt_d   = '0;
                  state_d = IDLE;
               end else if (rpt_q <= RPT_ONE) begin
                  raise   = 1'b1;
                  rpt_d   = RPT_PERIOD;
                  state_d = HOLD_REPEAT;
               end else begin
                  rpt_d = rpt_q - RPT_ONE;
               end
            end
            default: begin
               rpt_d   = '0;
               state_d = IDLE;
            end
         endcase
         evt_d = raise | (evt_q & ~btn_ack[bi]);
      end

      assign btn_evt[bi] = evt_q;
   end

   assign btn_level = btn_lvl;
   assign sw_level  = sw_lvl;

endmodule
